regfile_wr32: RTL and testbench
===============================

# regfile_wr32

Write side of the MIPS 32-entry general-purpose register bank. It decodes a 5-bit write address into 32 one-hot register enables and holds the 32 N-bit registers. It presents all of them as a packed array for the read-port selectors. It also keeps a per-register pending (scoreboard) bit so the pipeline can stall on registers with an outstanding producer.

## Interface
- N, default 32, register data width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable for this cycle
- wa  input  5  write register address (0..31)
- wd  input  N  write data
- claim  input  1  mark register ca as pending (issue of an instruction writing ca)
- ca  input  5  claimed destination address
- q  output  [0:31][N-1:0]  current register contents; q[i] is register i, ascending index matches read-port selector packing
- busy  output  32  pending bit per register; busy[i] for register i
- wr_ack  output  1  registered pulse: a write to a nonzero register committed on the previous edge

## Operation
- Reset (rst_n low, asynchronous): every q[i] = 0, busy = 0, wr_ack = 0. Holds while rst_n low. Release is sampled on the next rising edge.
- Write: when we=1 at a rising edge and wa != 0, register wa loads wd. All other registers hold.
- Register 0 is hardwired: q[0] = 0 always, writes to wa=0 are discarded, and busy[0] = 0 always.
- wr_ack is 1 in the cycle after an edge with we=1 and wa != 0, otherwise 0.
- Scoreboard, per register i != 0, evaluated on each edge:
  - claim=1 and ca=i sets busy[i].
  - we=1 and wa=i clears busy[i].
  - When both happen on the same i in the same cycle, claim wins and busy[i] stays 1 (a newer producer is outstanding). The data write still happens.
- Claim and write to different registers in the same cycle are independent.
- A write to a register whose busy bit is 0 is legal and simply updates data.
- Claim of ca=0 is ignored.
- No internal write-to-read bypass: q reflects only committed state.

## Timing
- Write latency 1: wd appears on q[wa] immediately after the capturing edge. A same-cycle read of q sees the old value.
- busy updates on the same edge as the triggering claim or write. It is visible in the following cycle.
- wr_ack is asserted for exactly one cycle per qualifying write. Back-to-back writes give a continuous wr_ack.
- Reset asserted mid-operation clears all state immediately, regardless of clock. A write presented in the same cycle as reset assertion is lost.
- All outputs come directly from flops. There is no combinational path from inputs to outputs.

## Structure
- The shared package mips_pkg holds:
  - REG_COUNT = 32
  - REG_ADDR_W = 5
  - typedef reg_addr_t as logic [REG_ADDR_W-1:0]
- The read-port selectors also import mips_pkg.
- One sub-module, dec5to32: a combinational 5-to-32 one-hot decoder with an enable input. It is instantiated twice: once for the write enables (en = we) and once for the claim enables (en = claim).
- Register storage and the scoreboard live in regfile_wr32 as per-index always_ff blocks. Index 0 is tied to zero.

## Test plan
- Reset, then release; write wa=5, wd=32'hDEADBEEF → next cycle q[5]=32'hDEADBEEF, wr_ack=1, all other q[i]=0.
- Write wa=0, wd=32'hFFFFFFFF → q[0] stays 0, wr_ack=0. Claim ca=0 → busy[0] stays 0.
- Claim ca=9 → busy[9]=1. Three cycles later, write wa=9, wd=32'h12345678 → busy[9]=0, q[9]=32'h12345678.
- Same cycle: claim ca=7 and write wa=7, wd=32'hA5A5A5A5 → q[7]=32'hA5A5A5A5, busy[7]=1.
- Fill all 31 writable registers with their index on back-to-back cycles → wr_ack high for 31 consecutive cycles, q[i]=i for i=1..31.
- With q[3]=32'h1 and busy[3]=1, pulse rst_n low between clock edges → q[3]=0, busy=0, wr_ack=0 immediately, before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS register-bank definitions. The write side and the read-port
// selectors both import this package.
package mips_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/dec5to32.sv
// 5-to-32 one-hot decoder with enable. When en is low, the output is all zeros.
module dec5to32
  import mips_pkg::*;
(
  input  logic                 en,
  input  reg_addr_t            a,
  output logic [REG_COUNT-1:0] y
);
  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end
endmodule

// File: rtl/regfile_wr32.sv
// Write side of the 32-entry GPR bank. It holds the registers and the per-register
// pending bit. r0 is tied to zero, and every output is driven straight from a flop.
module regfile_wr32
  import mips_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  reg_addr_t                     wa,
  input  logic [N-1:0]                  wd,
  input  logic                          claim,
  input  reg_addr_t                     ca,
  output logic [0:REG_COUNT-1][N-1:0]   q,
  output logic [REG_COUNT-1:0]          busy,
  output logic                          wr_ack
);
  logic [REG_COUNT-1:0] wr_en, cl_en;
  logic [1:0]           vld_pipe;
  logic                 unused_cl0;

  dec5to32 u_dec_wr (.en(we),    .a(wa), .y(wr_en));
  dec5to32 u_dec_cl (.en(claim), .a(ca), .y(cl_en));

  // A claim of r0 decodes normally, but nothing consumes it.
  assign unused_cl0  = cl_en[0];
  assign vld_pipe[0] = |wr_en[REG_COUNT-1:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[1] <= 1'b0;
    else        vld_pipe[1] <= vld_pipe[0];
  end
  assign wr_ack = vld_pipe[1];

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign q[i]    = '0;
      assign busy[i] = 1'b0;
    end else begin : g_rw
      logic [N-1:0] r;
      logic         b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r <= '0;
        else if (wr_en[i]) r <= wd;
      end
      // A claim beats a same-cycle write: that claim is a newer, still-outstanding producer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        b <= 1'b0;
        else if (cl_en[i]) b <= 1'b1;
        else if (wr_en[i]) b <= 1'b0;
      end
      assign q[i]    = r;
      assign busy[i] = b;
    end
  end
endmodule

// File: tb/tb_regfile_wr32.sv
// Scoreboard bench for regfile_wr32. Stimulus queues expected values tagged with
// the cycle in which they must hold, and a monitor pops them and compares.
module tb_regfile_wr32;
  import mips_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    we = 1'b0, claim = 1'b0;
  reg_addr_t               wa = '0, ca = '0;
  logic [31:0]             wd = '0;
  logic [0:31][31:0]       q;
  logic [31:0]             busy;
  logic                    wr_ack;

  regfile_wr32 #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .claim(claim), .ca(ca), .q(q), .busy(busy), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          when;
    int          kind;   // 0 q[idx], 1 busy[idx], 2 wr_ack, 3 busy vector
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q_exp[$];
  int   cyc = 0;
  int   total = 0, bad = 0;
  event ev_chk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(int when, int kind, int idx, logic [31:0] val, string name);
    exp_t e;
    e.when = when; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    q_exp.push_back(e);
  endtask

  // Monitor: on each negedge (or on an immediate-check event), it pops and compares every due entry.
  initial begin
    forever begin
      @(negedge clk or ev_chk);
      while (q_exp.size() > 0 && q_exp[0].when <= cyc) begin
        exp_t        e;
        logic [31:0] act;
        e = q_exp.pop_front();
        case (e.kind)
          0:       act = q[e.idx];
          1:       act = {31'b0, busy[e.idx]};
          2:       act = {31'b0, wr_ack};
          default: act = busy;
        endcase
        total++;
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
        end
      end
    end
  end

  task automatic drv(logic w, int a, logic [31:0] d, logic c, int ca_i);
    @(posedge clk); #1;
    we = w; wa = reg_addr_t'(a); wd = d; claim = c; ca = reg_addr_t'(ca_i);
  endtask

  task automatic idle();
    drv(1'b0, 0, 32'h0, 1'b0, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push(cyc, 0, 5, 32'h0, "reset_q5");
    push(cyc, 3, 0, 32'h0, "reset_busy");
    push(cyc, 2, 0, 32'h0, "reset_wr_ack");
    rst_n = 1'b1;

    // Basic write
    drv(1'b1, 5, 32'hDEADBEEF, 1'b0, 0);
    push(cyc + 1, 0, 5, 32'hDEADBEEF, "wr_q5");
    push(cyc + 1, 2, 0, 32'h1,        "wr_ack_q5");
    push(cyc + 1, 0, 4, 32'h0,        "wr_q4_untouched");
    push(cyc + 1, 0, 6, 32'h0,        "wr_q6_untouched");

    // r0 write and r0 claim are both discarded
    drv(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0);
    push(cyc + 1, 0, 0, 32'h0,        "r0_write_q0");
    push(cyc + 1, 2, 0, 32'h0,        "r0_write_no_ack");
    push(cyc + 1, 1, 0, 32'h0,        "r0_claim_busy0");
    push(cyc + 1, 0, 5, 32'hDEADBEEF, "q5_holds");

    // Claim r9, then write it three cycles later
    drv(1'b0, 0, 32'h0, 1'b1, 9);
    push(cyc + 1, 1, 9, 32'h1, "claim9_busy");
    push(cyc + 1, 2, 0, 32'h0, "claim9_no_ack");
    idle();
    idle();
    push(cyc + 1, 1, 9, 32'h1, "busy9_holds");
    drv(1'b1, 9, 32'h12345678, 1'b0, 0);
    push(cyc + 1, 1, 9, 32'h0,        "write9_clears_busy");
    push(cyc + 1, 0, 9, 32'h12345678, "write9_q");

    // Same-cycle claim and write to r7: the claim wins and the data still lands
    drv(1'b1, 7, 32'hA5A5A5A5, 1'b1, 7);
    push(cyc + 1, 0, 7, 32'hA5A5A5A5, "claimwr7_q");
    push(cyc + 1, 1, 7, 32'h1,        "claimwr7_busy");
    push(cyc + 1, 2, 0, 32'h1,        "claimwr7_ack");

    // Claim and write to different registers are independent
    drv(1'b1, 7, 32'h00000011, 1'b1, 3);
    push(cyc + 1, 0, 7, 32'h00000011, "indep_q7");
    push(cyc + 1, 1, 7, 32'h0,        "indep_busy7_clr");
    push(cyc + 1, 1, 3, 32'h1,        "indep_busy3_set");

    // Fill r1..r31 back to back with their own index
    for (int i = 1; i < 32; i++) begin
      drv(1'b1, i, 32'(i), 1'b0, 0);
      push(cyc + 1, 2, 0, 32'h1,  $sformatf("fill_ack_%0d", i));
      push(cyc + 1, 0, i, 32'(i), $sformatf("fill_q_%0d", i));
    end
    idle();
    push(cyc + 1, 2, 0, 32'h0, "fill_ack_drop");
    for (int i = 0; i < 32; i++)
      push(cyc + 1, 0, i, 32'(i), $sformatf("fill_final_q_%0d", i));

    // Set up q[3]=1, busy[3]=1, then pulse reset between edges
    drv(1'b1, 3, 32'h1, 1'b1, 3);
    @(posedge clk); #1;
    we = 1'b1; wa = 5'd4; wd = 32'h77; claim = 1'b0; ca = '0;
    push(cyc, 0, 3, 32'h1, "pre_rst_q3");
    push(cyc, 1, 3, 32'h1, "pre_rst_busy3");
    push(cyc, 2, 0, 32'h1, "pre_rst_ack");
    ->ev_chk;
    #1 rst_n = 1'b0;
    #1;
    push(cyc, 0, 3, 32'h0, "async_rst_q3");
    push(cyc, 3, 0, 32'h0, "async_rst_busy");
    push(cyc, 2, 0, 32'h0, "async_rst_ack");
    ->ev_chk;
    @(posedge clk); #1;
    rst_n = 1'b1;
    we = 1'b0; claim = 1'b0;
    push(cyc, 0, 4, 32'h0, "write_lost_in_rst");

    // Writes work again after reset
    drv(1'b1, 31, 32'hCAFEF00D, 1'b0, 0);
    push(cyc + 1, 0, 31, 32'hCAFEF00D, "post_rst_q31");
    push(cyc + 1, 2, 0,  32'h1,        "post_rst_ack");
    idle();

    for (int k = 0; k < 20 && q_exp.size() > 0; k++) @(posedge clk);
    @(posedge clk); #1;
    if (q_exp.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
